// File: rtl/aes_round_sequencer.sv
// Sequences one AES-128 encryption over a shared step-unit port, fetching round keys by index.
// Latency sum(k_i+1) edges from accept to finish; start low in ISSUE/GAP aborts; finish/err held until start drops.
module aes_round_sequencer #(
  parameter int NROUNDS = 10,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] in,
  output logic         finish,
  output logic [127:0] out,
  output logic         err,
  output logic [1:0]   step_sel,
  output logic         step_start,
  output logic [127:0] step_in,
  output logic [127:0] step_key,
  input  logic         step_finish,
  input  logic [127:0] step_out,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk
);
  localparam int NOPS = 4 * NROUNDS;
  localparam int OPW  = $clog2(NOPS + 1);
  localparam int TW   = $clog2(TIMEOUT);
  localparam logic [OPW-1:0] OP_ONE   = OPW'(1);
  localparam logic [OPW-1:0] OP_END   = OPW'(NOPS);
  localparam logic [TW-1:0]  TMO_ONE  = TW'(1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [3:0]     RND_LAST = 4'(NROUNDS);
  localparam logic [1:0]     SEL_MIX  = 2'd2;
  localparam logic [1:0]     SEL_ARK  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP,
    S_DONE,
    S_ERR
  } state_t;

  state_t         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [127:0]   data_q, data_d;
  logic [127:0]   out_q, out_d;

  logic [OPW-1:0] op_m1;
  logic [3:0]     round;
  logic [1:0]     sel;
  logic           op_live;

  // op 0 is the initial key add; afterwards four ops per round, final round swaps Mix for AddRoundKey
  assign op_m1 = op_q - OP_ONE;

  always_comb begin
    round = 4'd0;
    sel   = SEL_ARK;
    if (op_q != '0) begin
      round = 4'(op_m1 >> 2) + 4'd1;
      sel   = op_m1[1:0];
      if (round == RND_LAST && sel == SEL_MIX) begin
        sel = SEL_ARK;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    tmo_d   = tmo_q;
    data_d  = data_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          data_d  = in;
          op_d    = '0;
          tmo_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!start) begin
          state_d = S_IDLE;
        end else if (step_finish) begin
          data_d  = step_out;
          op_d    = op_q + OP_ONE;
          tmo_d   = '0;
          state_d = S_GAP;
        end else if (tmo_q == TMO_LAST) begin
          tmo_d   = '0;
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      S_GAP: begin
        if (!start) begin
          state_d = S_IDLE;
        end else if (op_q == OP_END) begin
          out_d   = data_q;
          state_d = S_DONE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_DONE, S_ERR: begin
        if (!start) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      tmo_q   <= '0;
      data_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      out_q   <= out_d;
    end
  end

  assign op_live    = (state_q == S_ISSUE) || (state_q == S_GAP);
  assign step_start = (state_q == S_ISSUE);
  assign step_sel   = op_live ? sel : 2'd0;
  assign rk_idx     = op_live ? round : 4'd0;
  assign step_in    = data_q;
  assign step_key   = rk;
  assign finish     = (state_q == S_DONE) || (state_q == S_ERR);
  assign err        = (state_q == S_ERR);
  assign out        = out_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench: behavioural AES step units and key expansion around the sequencer, scoreboard on finish.
module tb_aes_round_sequencer;
  localparam int NR   = 10;
  localparam int TMO  = 64;
  localparam int NOPS = 4 * NR;
  localparam logic [127:0] FIPS_KEY = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
  localparam logic [127:0] FIPS_PT  = 128'h340737e0a29831318d305a88a8f64332;
  localparam logic [127:0] FIPS_CT  = 128'h320b6a19978511dcfb09dc021d842539;

  typedef struct {
    logic [127:0] out;
    logic         err;
    bit           chk_out;
    int           lat;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [127:0] in_d = '0;
  logic         finish, err, step_start, step_finish;
  logic [127:0] out, step_in, step_key, step_out, rk;
  logic [1:0]   step_sel;
  logic [3:0]   rk_idx;

  aes_round_sequencer #(.NROUNDS(NR), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .in(in_d),
    .finish(finish), .out(out), .err(err),
    .step_sel(step_sel), .step_start(step_start), .step_in(step_in), .step_key(step_key),
    .step_finish(step_finish), .step_out(step_out),
    .rk_idx(rk_idx), .rk(rk)
  );

  always #5 clk = ~clk;

  logic [7:0]   sbox [256];
  logic [127:0] rkeys [16];
  logic [1:0]   op_sel [NOPS];
  logic [3:0]   op_rnd [NOPS];
  int           k_tab [NOPS];
  int           hang_op = -1;
  bit           real_mode = 1'b1;
  int           stub_op = 0;
  int           stub_cnt = 0;
  int           cyc = 0;
  int           n_chk = 0;
  int           n_pass = 0;
  exp_t         exp_q [$];
  logic [5:0]   trace_q [$];
  bit           trace_on = 1'b0;
  logic [127:0] last_good = '0;

  // ---------------- AES reference arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v};
    return t[15-n -: 8];
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox[s[8*i +: 8]];
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[8*(r + 4*c) +: 8] = s[8*(r + 4*((c + r) % 4)) +: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8]; a1 = s[32*c+8 +: 8]; a2 = s[32*c+16 +: 8]; a3 = s[32*c+24 +: 8];
      o[32*c    +: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[32*c+8  +: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[32*c+16 +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[32*c+24 +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[7:0], t[31:8]};
        for (int b = 0; b < 4; b++) t[8*b +: 8] = sbox[t[8*b +: 8]];
        t[7:0] = t[7:0] ^ rc;
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) rkeys[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rkeys[0];
    for (int r = 1; r < NR; r++) s = mix_columns(shift_rows(sub_bytes(s))) ^ rkeys[r];
    return shift_rows(sub_bytes(s)) ^ rkeys[NR];
  endfunction

  function automatic logic [127:0] tag_ref(input logic [127:0] pt);
    logic [127:0] s;
    s = pt;
    for (int i = 0; i < NOPS; i++) s = s ^ {122'd0, op_sel[i], op_rnd[i]};
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- step-unit and key-expansion models ----------------
  assign rk = rkeys[rk_idx];

  always_comb begin
    step_out = step_in ^ {122'd0, step_sel, rk_idx};
    if (real_mode) begin
      case (step_sel)
        2'd0:    step_out = sub_bytes(step_in);
        2'd1:    step_out = shift_rows(step_in);
        2'd2:    step_out = mix_columns(step_in);
        default: step_out = step_in ^ step_key;
      endcase
    end
  end

  // finish arrives on the k-th edge of each op; hang_op never finishes
  always_comb begin
    step_finish = 1'b0;
    if (step_start && stub_op < NOPS && stub_op != hang_op)
      step_finish = (stub_cnt >= k_tab[stub_op] - 1);
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!start) begin
      stub_op  <= 0;
      stub_cnt <= 0;
    end else if (step_start) begin
      if (step_finish) begin
        stub_op  <= stub_op + 1;
        stub_cnt <= 0;
      end else begin
        stub_cnt <= stub_cnt + 1;
      end
    end else begin
      stub_cnt <= 0;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, want);
  endtask

  // ---------------- monitor: scoreboard and op trace ----------------
  logic fin_prev = 1'b0;
  exp_t mon_e;

  always @(negedge clk) begin
    if (rst && finish && !fin_prev) begin
      chk("sb_pending", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("result_err", err, mon_e.err);
        if (mon_e.chk_out) chk("result_out", out, mon_e.out);
        chk("latency", cyc - mon_e.acc, mon_e.lat);
      end
    end
    fin_prev = finish;
    if (trace_on && step_start && step_finish) begin
      chk("trace_pending", trace_q.size() > 0, 1'b1);
      if (trace_q.size() > 0) chk("op_trace", {step_sel, rk_idx}, trace_q.pop_front());
    end
  end

  // ---------------- driver ----------------
  task automatic launch(input logic [127:0] pt, input logic [127:0] key, input bit realm,
                        input int kmax, input int hang, input bit push);
    exp_t e;
    int   lat;
    expand_key(key);
    real_mode = realm;
    hang_op   = hang;
    lat = 0;
    for (int i = 0; i < NOPS; i++) begin
      k_tab[i] = $urandom_range(kmax, 1);
      if (hang < 0 || i < hang) lat += k_tab[i] + 1;
    end
    e.err     = (hang >= 0);
    e.out     = (hang >= 0) ? last_good : (realm ? aes_ref(pt) : tag_ref(pt));
    e.chk_out = 1'b1;
    e.lat     = (hang >= 0) ? lat + TMO : lat;
    e.acc     = cyc + 1;
    if (push) begin
      exp_q.push_back(e);
      if (hang < 0) last_good = e.out;
    end
    in_d  = pt;
    start = 1'b1;
  endtask

  task automatic wait_finish(input string nm);
    int n;
    n = 0;
    while (!finish && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(nm, finish, 1'b1);
  endtask

  task automatic end_req();
    start = 1'b0;
    @(negedge clk);
    chk("finish_drop", finish, 1'b0);
    chk("err_drop", err, 1'b0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_finish"}, finish, 1'b0);
    chk({nm, "_err"}, err, 1'b0);
    chk({nm, "_step_start"}, step_start, 1'b0);
    chk({nm, "_step_sel"}, step_sel, 2'd0);
    chk({nm, "_rk_idx"}, rk_idx, 4'd0);
    chk({nm, "_out"}, out, 128'd0);
  endtask

  initial begin
    int n, run;
    bit seen;
    int idx;
    for (int x = 0; x < 256; x++) sbox[x] = sbox_calc(8'(x));
    for (int r = 0; r < 16; r++) rkeys[r] = '0;
    for (int i = 0; i < NOPS; i++) k_tab[i] = 1;
    idx = 0;
    op_sel[idx] = 2'd3; op_rnd[idx] = 4'd0; idx++;
    for (int r = 1; r < NR; r++)
      for (int s = 0; s < 4; s++) begin
        op_sel[idx] = 2'(s); op_rnd[idx] = 4'(r); idx++;
      end
    op_sel[idx] = 2'd0; op_rnd[idx] = 4'(NR); idx++;
    op_sel[idx] = 2'd1; op_rnd[idx] = 4'(NR); idx++;
    op_sel[idx] = 2'd3; op_rnd[idx] = 4'(NR);

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // FIPS-197 vector, one-cycle step units
    launch(FIPS_PT, FIPS_KEY, 1'b1, 1, -1, 1'b1);
    wait_finish("fips_finish");
    chk("fips_vector", out, FIPS_CT);
    end_req();

    // op order with tagging stub
    trace_on = 1'b1;
    for (int i = 0; i < NOPS; i++) trace_q.push_back({op_sel[i], op_rnd[i]});
    launch(rand128(), rand128(), 1'b0, 1, -1, 1'b1);
    wait_finish("tag_finish");
    end_req();
    trace_on = 1'b0;
    chk("trace_drained", trace_q.size(), 0);

    // back-to-back random requests with random step latencies
    for (int t = 0; t < 6; t++) begin
      launch(rand128(), rand128(), 1'b1, 4, -1, 1'b1);
      wait_finish("rand_finish");
      end_req();
    end

    // op 5 never finishes
    launch(rand128(), rand128(), 1'b1, 1, 5, 1'b1);
    n = 0; run = 0;
    while (!finish && n < 500) begin
      @(negedge clk);
      n++;
      if (!finish) run = step_start ? run + 1 : 0;
    end
    chk("tmo_finish", finish, 1'b1);
    chk("tmo_err", err, 1'b1);
    chk("tmo_cycles", run, TMO);
    chk("tmo_step_start", step_start, 1'b0);
    end_req();
    hang_op = -1;

    // abort at op 20
    launch(rand128(), rand128(), 1'b1, 2, -1, 1'b0);
    n = 0;
    while (!(stub_op == 20 && step_start) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach", stub_op == 20 && step_start, 1'b1);
    start = 1'b0;
    @(negedge clk);
    chk("abort_step_start", step_start, 1'b0);
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      seen |= finish;
    end
    chk("abort_no_finish", seen, 1'b0);
    chk("abort_out_hold", out, last_good);
    launch(FIPS_PT, FIPS_KEY, 1'b1, 3, -1, 1'b1);
    wait_finish("fips2_finish");
    chk("fips2_vector", out, FIPS_CT);
    end_req();

    // asynchronous reset during round 4
    launch(rand128(), rand128(), 1'b1, 2, -1, 1'b0);
    n = 0;
    while (!(stub_op == 13 && step_start) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach", stub_op == 13 && step_start, 1'b1);
    #2;
    rst   = 1'b0;
    start = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b1;
    last_good = '0;
    @(negedge clk);
    launch(rand128(), rand128(), 1'b1, 3, -1, 1'b1);
    wait_finish("post_rst_finish");
    end_req();

    repeat (3) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
